// File: rtl/debounce_pkg.sv
// Shared definitions for the debounce bank.
//   deb_state_t : per-channel debounce FSM state
//   width_for() : counter width helper, never returns less than one bit
package debounce_pkg;

  typedef enum logic {
    ST_STABLE   = 1'b0,
    ST_COUNTING = 1'b1
  } deb_state_t;

  // Bits needed to count from 0 to n-1; at least one bit.
  function automatic int unsigned width_for(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounce channel: 2-FF synchroniser, STABLE/COUNTING FSM with stability
// counter, registered debounced level and one-cycle rise/fall pulses, plus an
// optional hold counter producing a one-cycle long-press pulse.
// Optional feature macro: DEBOUNCE_LONG_PRESS_EN (o_long tied 0 when undefined).
// Ports:
//   i_clk    : system clock, all logic on posedge
//   i_rst_n  : asynchronous active-low reset
//   i_btn    : raw asynchronous button input
//   o_level  : debounced level (1 = pressed, after ACTIVE_LOW inversion)
//   o_rise   : one-cycle pulse on o_level 0->1
//   o_fall   : one-cycle pulse on o_level 1->0
//   o_long   : one-cycle pulse after LONG_PRESS_CYCLES cycles of o_level high
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES   = 270000,
  parameter int unsigned ACTIVE_LOW        = 0,
  parameter int unsigned LONG_PRESS_CYCLES = 27000000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_btn,
  output logic o_level,
  output logic o_rise,
  output logic o_fall,
  output logic o_long
);

  localparam int unsigned      CNT_W    = width_for(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic             POL      = (ACTIVE_LOW != 0);

  if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
    $error("debounce_channel: DEBOUNCE_CYCLES must be >= 2");
  end
  if (LONG_PRESS_CYCLES < 1) begin : g_bad_long
    $error("debounce_channel: LONG_PRESS_CYCLES must be >= 1");
  end

  logic             sync_meta;
  logic             sync_out;
  logic             s;
  deb_state_t       state;
  logic [CNT_W-1:0] cnt;

  // Synchroniser flops reset to the polarity value so the post-inversion
  // sample is 0 out of reset regardless of ACTIVE_LOW.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync_meta <= POL;
      sync_out  <= POL;
    end else begin
      sync_meta <= i_btn;
      sync_out  <= sync_meta;
    end
  end

  assign s = sync_out ^ POL;

  // A change is accepted only after DEBOUNCE_CYCLES consecutive samples that
  // differ from the current level; any agreeing sample abandons the count.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= ST_STABLE;
      cnt     <= '0;
      o_level <= 1'b0;
      o_rise  <= 1'b0;
      o_fall  <= 1'b0;
    end else begin
      o_rise <= 1'b0;
      o_fall <= 1'b0;
      case (state)
        ST_STABLE: begin
          if (s != o_level) begin
            state <= ST_COUNTING;
            cnt   <= CNT_ONE;
          end else begin
            cnt <= '0;
          end
        end
        ST_COUNTING: begin
          if (s == o_level) begin
            state <= ST_STABLE;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            o_level <= s;
            o_rise  <= s;
            o_fall  <= ~s;
            state   <= ST_STABLE;
            cnt     <= '0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: begin
          state <= ST_STABLE;
          cnt   <= '0;
        end
      endcase
    end
  end

`ifdef DEBOUNCE_LONG_PRESS_EN
  localparam int unsigned       HOLD_W   = width_for(LONG_PRESS_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_PRESS_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);

  logic [HOLD_W-1:0] hold;

  // Saturating at HOLD_MAX guarantees at most one o_long per press.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      hold   <= '0;
      o_long <= 1'b0;
    end else begin
      o_long <= 1'b0;
      if (!o_level) begin
        hold <= '0;
      end else if (hold != HOLD_MAX) begin
        hold <= hold + HOLD_ONE;
        if (hold == HOLD_MAX - HOLD_ONE) begin
          o_long <= 1'b1;
        end
      end
    end
  end
`else
  assign o_long = 1'b0;
`endif

endmodule

// File: rtl/debounce_bank.sv
// NUM_CH independent button/switch debouncers; wiring only, one
// debounce_channel per input bit.
// Optional feature macro: DEBOUNCE_LONG_PRESS_EN (enables o_long pulses).
// Ports:
//   i_clk    : system clock
//   i_rst_n  : asynchronous active-low reset
//   i_btn    : [NUM_CH] raw asynchronous button inputs
//   o_level  : [NUM_CH] debounced levels (1 = pressed)
//   o_rise   : [NUM_CH] one-cycle pulses on level 0->1
//   o_fall   : [NUM_CH] one-cycle pulses on level 1->0
//   o_long   : [NUM_CH] one-cycle long-press pulses (0 without the macro)
module debounce_bank
  import debounce_pkg::*;
#(
  parameter int unsigned NUM_CH            = 4,
  parameter int unsigned DEBOUNCE_CYCLES   = 270000,
  parameter int unsigned ACTIVE_LOW        = 0,
  parameter int unsigned LONG_PRESS_CYCLES = 27000000
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [NUM_CH-1:0] i_btn,
  output logic [NUM_CH-1:0] o_level,
  output logic [NUM_CH-1:0] o_rise,
  output logic [NUM_CH-1:0] o_fall,
  output logic [NUM_CH-1:0] o_long
);

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CYCLES  (DEBOUNCE_CYCLES),
      .ACTIVE_LOW       (ACTIVE_LOW),
      .LONG_PRESS_CYCLES(LONG_PRESS_CYCLES)
    ) u_channel (
      .i_clk  (i_clk),
      .i_rst_n(i_rst_n),
      .i_btn  (i_btn[ch]),
      .o_level(o_level[ch]),
      .o_rise (o_rise[ch]),
      .o_fall (o_fall[ch]),
      .o_long (o_long[ch])
    );
  end

endmodule

// File: tb/tb_debounce_bank.sv
// Bench for debounce_bank: two instances (ACTIVE_LOW=0 and ACTIVE_LOW=1) share
// the same pins; a sample-window reference model predicts every output each
// cycle, and directed scenarios pin latencies and pulse masks with literals.
module tb_debounce_bank;

  localparam int unsigned NCH = 4;
  localparam int unsigned DC  = 8;
  localparam int unsigned LPC = 32;
`ifdef DEBOUNCE_LONG_PRESS_EN
  localparam bit LONG_EN = 1'b1;
`else
  localparam bit LONG_EN = 1'b0;
`endif

  logic           clk   = 1'b0;
  logic           rst_n = 1'b0;
  logic [NCH-1:0] btn   = '0;

  logic [NCH-1:0] lvl0, rise0, fall0, long0;
  logic [NCH-1:0] lvl1, rise1, fall1, long1;

  always #5 clk = ~clk;

  debounce_bank #(
    .NUM_CH(NCH), .DEBOUNCE_CYCLES(DC), .ACTIVE_LOW(0), .LONG_PRESS_CYCLES(LPC)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_btn(btn),
    .o_level(lvl0), .o_rise(rise0), .o_fall(fall0), .o_long(long0)
  );

  debounce_bank #(
    .NUM_CH(NCH), .DEBOUNCE_CYCLES(DC), .ACTIVE_LOW(1), .LONG_PRESS_CYCLES(LPC)
  ) dut_al (
    .i_clk(clk), .i_rst_n(rst_n), .i_btn(btn),
    .o_level(lvl1), .o_rise(rise1), .o_fall(fall1), .o_long(long1)
  );

  int unsigned total = 0;
  int unsigned bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: level flips once the last DC synchronised samples since
  // the previous flip/reset all disagree with it; o_long fires exactly LPC
  // cycles after the level went high if it is still high.
  logic [NCH-1:0] m_s1[2], m_s2[2], m_level[2], m_rise[2], m_fall[2], m_long[2];
  logic [DC-1:0]  m_hist[2][NCH];
  int unsigned    m_nv[2][NCH];
  longint         m_since[2][NCH];
  longint         m_cyc;

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_s1[k] = '0; m_s2[k] = '0; m_level[k] = '0;
      m_rise[k] = '0; m_fall[k] = '0; m_long[k] = '0;
      for (int ch = 0; ch < NCH; ch++) begin
        m_hist[k][ch] = '0; m_nv[k][ch] = 0; m_since[k][ch] = 0;
      end
    end
    m_cyc = 0;
  endtask

  task automatic model_edge();
    logic [NCH-1:0] s_cur;
    logic           old;
    logic [DC-1:0]  want;
    m_cyc++;
    for (int k = 0; k < 2; k++) begin
      s_cur    = m_s2[k];
      m_s2[k]  = m_s1[k];
      m_s1[k]  = btn ^ ((k == 1) ? {NCH{1'b1}} : {NCH{1'b0}});
      m_rise[k] = '0; m_fall[k] = '0; m_long[k] = '0;
      for (int ch = 0; ch < NCH; ch++) begin
        old = m_level[k][ch];
        m_hist[k][ch] = {m_hist[k][ch][DC-2:0], s_cur[ch]};
        if (m_nv[k][ch] < DC) m_nv[k][ch]++;
        want = {DC{~old}};
        if (m_nv[k][ch] >= DC && m_hist[k][ch] == want) begin
          m_level[k][ch] = ~old;
          m_nv[k][ch]    = 0;
          if (!old) begin
            m_rise[k][ch]  = 1'b1;
            m_since[k][ch] = m_cyc;
          end else begin
            m_fall[k][ch] = 1'b1;
          end
        end
        if (LONG_EN && old && (m_cyc - m_since[k][ch] == longint'(LPC)))
          m_long[k][ch] = 1'b1;
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else        model_edge();
    end
  end

  // Per-cycle comparison of both instances against the model.
  initial begin
    forever begin
      @(negedge clk);
      chk("level",    32'(lvl0),  32'(m_level[0]));
      chk("rise",     32'(rise0), 32'(m_rise[0]));
      chk("fall",     32'(fall0), 32'(m_fall[0]));
      chk("long",     32'(long0), 32'(m_long[0]));
      chk("al_level", 32'(lvl1),  32'(m_level[1]));
      chk("al_rise",  32'(rise1), 32'(m_rise[1]));
      chk("al_fall",  32'(fall1), 32'(m_fall[1]));
      chk("al_long",  32'(long1), 32'(m_long[1]));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Counts active edges until the selected pulse vector is non-zero;
  // n = -1 if the budget runs out.
  task automatic wait_pulse(input int which, input int budget,
                            output int n, output logic [NCH-1:0] seen);
    bit done;
    n = -1; seen = '0; done = 1'b0;
    for (int i = 1; i <= budget && !done; i++) begin
      @(posedge clk);
      #1;
      case (which)
        0:       seen = rise0;
        1:       seen = fall0;
        2:       seen = rise1;
        default: seen = long0;
      endcase
      if (seen != '0) begin
        n = i;
        done = 1'b1;
      end
    end
  endtask

  int             n;
  logic [NCH-1:0] seen;
  int             pulses;

  initial begin
    // Reset with all pins high: everything held at 0.
    btn = 4'hF; rst_n = 1'b0;
    cyc(3);
    chk("rst_level", 32'(lvl0), 0);
    chk("rst_rise",  32'(rise0), 0);
    chk("rst_al_level", 32'(lvl1), 0);
    btn = 4'h0;
    cyc(2);
    chk("rst_hold_level", 32'(lvl0), 0);
    rst_n = 1'b1;

    // Active-low instance: pins low means pressed.
    wait_pulse(2, 30, n, seen);
    chk("al_rise_lat",  32'(n), 10);
    chk("al_rise_mask", 32'(seen), 32'h0000000F);

    // Clean press on ch0.
    cyc(5);
    btn = 4'b0001;
    wait_pulse(0, 30, n, seen);
    chk("press_lat",   32'(n), 10);
    chk("press_mask",  32'(seen), 32'h1);
    chk("press_level", 32'(lvl0), 32'h1);

    // Bounce on ch1: 13 toggles spaced 3 cycles, ends high.
    cyc(1);
    pulses = 0;
    for (int t = 0; t < 13; t++) begin
      btn[1] = ~btn[1];
      if (t < 12) begin
        repeat (3) begin
          @(posedge clk);
          #1;
          pulses += int'(rise0[1]) + int'(fall0[1]);
        end
      end
    end
    wait_pulse(0, 30, n, seen);
    chk("bounce_pulses", 32'(pulses), 0);
    chk("bounce_lat",    32'(n), 10);
    chk("bounce_mask",   32'(seen), 32'h2);

    // Parallel rise and fall on ch1/ch3.
    btn = 4'b0000;
    cyc(15);
    btn = 4'b1010;
    wait_pulse(0, 30, n, seen);
    chk("par_rise_lat",  32'(n), 10);
    chk("par_rise_mask", 32'(seen), 32'hA);
    cyc(3);
    btn = 4'b0000;
    wait_pulse(1, 30, n, seen);
    chk("par_fall_lat",  32'(n), 10);
    chk("par_fall_mask", 32'(seen), 32'hA);

    // Reset in the middle of a count on ch2.
    cyc(12);
    btn = 4'b0100;
    cyc(5);
    chk("midrst_pre_level", 32'(lvl0), 0);
    rst_n = 1'b0;
    cyc(2);
    chk("midrst_level", 32'(lvl0), 0);
    chk("midrst_rise",  32'(rise0), 0);
    rst_n = 1'b1;
    wait_pulse(0, 30, n, seen);
    chk("midrst_lat",  32'(n), 10);
    chk("midrst_mask", 32'(seen), 32'h4);

    // Long press on ch3.
    btn = 4'b0000;
    cyc(15);
    btn = 4'b1000;
    wait_pulse(0, 30, n, seen);
    chk("long_rise_lat", 32'(n), 10);
    pulses = 0;
`ifdef DEBOUNCE_LONG_PRESS_EN
    wait_pulse(3, 60, n, seen);
    chk("long_lat",  32'(n), 32);
    chk("long_mask", 32'(seen), 32'h8);
    repeat (20) begin
      @(posedge clk);
      #1;
      pulses += int'(long0[3]);
    end
    chk("long_extra", 32'(pulses), 0);
`else
    repeat (50) begin
      @(posedge clk);
      #1;
      pulses += int'(long0 != '0);
    end
    chk("long_off", 32'(pulses), 0);
`endif

    // Randomised phase: sparse bit flips with random holds, occasional reset.
    cyc(1);
    for (int it = 0; it < 300; it++) begin
      btn = btn ^ (4'($urandom) & 4'($urandom));
      if ($urandom_range(0, 39) == 0) begin
        rst_n = 1'b0;
        cyc($urandom_range(1, 3));
        rst_n = 1'b1;
      end
      cyc($urandom_range(1, 14));
    end
    cyc(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

endmodule
